// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, flag struct, drain state and classifier
// Purpose: common types for the product drain stage.
//   FP_W/EXP_W/MAN_W : IEEE-754 single-precision field widths
//   fp_flags_t       : {nan, inf, zero, subnormal}, one-hot or all-zero
//   drain_state_t    : input handshake FSM states
//   fp_classify      : combinational class of a 32-bit product
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic subnormal;
    } fp_flags_t;

    typedef enum logic {
        IDLE,
        ACK
    } drain_state_t;

    function automatic fp_flags_t fp_classify(input logic [FP_W-1:0] v);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        fp_flags_t        f;
        e           = v[FP_W-2 -: EXP_W];
        m           = v[MAN_W-1:0];
        f.nan       = (e == {EXP_W{1'b1}}) && (m != '0);
        f.inf       = (e == {EXP_W{1'b1}}) && (m == '0);
        f.zero      = (e == '0) && (m == '0);
        f.subnormal = (e == '0) && (m != '0);
        return f;
    endfunction

endpackage

// File: rtl/fp_result_drain_if.sv
// rtl/fp_result_drain_if.sv - product handshake and result stream bundle
// Purpose: groups the multiplier-side four-phase handshake, the consumer-side
// valid/ready stream and the status outputs of fp_result_drain.
//   resultReady/resBus/resultAccept : multiplier four-phase handshake
//   outValid/outReady/outData/outFlags : FWFT head entry stream
//   level/overflowSeen              : occupancy and sticky overflow status
// Modports: slave = drain side, master = multiplier/consumer side.
interface fp_result_drain_if #(
    parameter int DEPTH = 4
);
    import fp_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             resultReady;
    logic [FP_W-1:0]  resBus;
    logic             resultAccept;
    logic             outValid;
    logic             outReady;
    logic [FP_W-1:0]  outData;
    logic [3:0]       outFlags;
    logic [CNT_W-1:0] level;
    logic             overflowSeen;

    modport slave (
        input  resultReady, resBus, outReady,
        output resultAccept, outValid, outData, outFlags, level, overflowSeen
    );

    modport master (
        output resultReady, resBus, outReady,
        input  resultAccept, outValid, outData, outFlags, level, overflowSeen
    );

endinterface

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous first-word-fall-through FIFO
// Purpose: DEPTH x WIDTH buffer; head entry is always visible on data_o.
//   clk, rst     : clock, synchronous active-high reset
//   push_i/data_i: write strobe and data (ignored when full)
//   pop_i        : remove head entry (ignored when empty)
//   data_o       : head entry, don't-care when empty
//   full_o/empty_o/level_o : status
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == CNT_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer increment wraps naturally.
    always_comb begin
        wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is not reset; contents are qualified by level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fp_result_drain.sv
// rtl/fp_result_drain.sv - classify and buffer multiplier products
// Purpose: accepts products over the resultReady/resultAccept four-phase
// handshake, tags them with IEEE-754 class flags and queues them in an FWFT
// FIFO presented as a valid/ready stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_result_drain_if.slave (handshake, stream, status)
module fp_result_drain
    import fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fp_result_drain_if.slave    bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    drain_state_t     state_q;
    logic             accept_q;
    logic             ovf_q;
    logic             push;
    logic             full;
    logic             empty;
    fp_flags_t        flags_in;
    logic [35:0]      head;
    logic [CNT_W-1:0] level;

    assign flags_in = fp_classify(bus.resBus);

    // Capture only from IDLE, so one resultReady pulse yields one entry
    // regardless of how long it is held.
    assign push = (state_q == IDLE) && bus.resultReady && !full;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({flags_in, bus.resBus}),
        .pop_i   (bus.outReady),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            accept_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.resultReady) begin
                        if (!full) begin
                            state_q  <= ACK;
                            accept_q <= 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!bus.resultReady) begin
                        state_q  <= IDLE;
                        accept_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    accept_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.resultAccept = accept_q;
    assign bus.overflowSeen = ovf_q;
    assign bus.outValid     = !empty;
    assign bus.outData      = head[31:0];
    assign bus.outFlags     = head[35:32];
    assign bus.level        = level;

endmodule
